// File: rtl/uart_sender_if.sv
// Peripheral-side signal bundle of the UART sender: write strobe/data, buffer
// status, and the serial line with its activity flag.
interface uart_sender_if;
  logic [7:0] TX_DATA;
  logic       TX_EN;
  logic       TX_STATUS;
  logic       tx;
  logic       busy;

  modport slave (
    input  TX_DATA,
    input  TX_EN,
    output TX_STATUS,
    output tx,
    output busy
  );

  modport master (
    output TX_DATA,
    output TX_EN,
    input  TX_STATUS,
    input  tx,
    input  busy
  );
endinterface

// File: rtl/uart_sender.sv
// 8N1 UART transmitter fed by a 4-entry byte FIFO; BAUD_DIV clocks per bit,
// back-to-back frames with no idle gap when the FIFO holds more bytes.
module uart_sender #(
  parameter int unsigned BAUD_DIV = 10416
) (
  input  logic          clk,
  input  logic          reset,
  uart_sender_if.slave  bus
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_reg, state_next;
  logic [15:0] baud_reg, baud_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic        tx_reg, tx_next;

  logic [7:0]  fifo_mem [4];
  logic [1:0]  rd_ptr_reg, wr_ptr_reg;
  logic [2:0]  count_reg;

  logic        push;
  logic        pop;
  logic        baud_end;

  // Fullness is judged before this edge's pop, so a full FIFO drops the
  // write even when a byte leaves on the same edge.
  assign push     = bus.TX_EN && (count_reg != 3'd4);
  assign baud_end = (baud_reg == BAUD_LAST);

  assign bus.tx        = tx_reg;
  assign bus.TX_STATUS = (count_reg != 3'd4);
  assign bus.busy      = (state_reg != IDLE) || (count_reg != 3'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= bus.TX_DATA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= 2'd0;
      wr_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 2'd1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 2'd1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      baud_reg  <= 16'd0;
      bit_reg   <= 3'd0;
      shift_reg <= 8'd0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    tx_next    = 1'b1;

    case (state_reg)
      IDLE: begin
        baud_next = 16'd0;
        if (count_reg != 3'd0) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr_reg];
          state_next = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_next  = 16'd0;
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next  = 16'd0;
          shift_next = shift_reg >> 1;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_next = 16'd0;
          // Chain straight into the next start bit when more bytes wait.
          if (count_reg != 3'd0) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr_reg];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = 16'd0;
      end
    endcase

    // tx is registered from the state being entered so the line never glitches.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_sender.md
UART_SENDER -- requirements
Module: uart_sender

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 10416, giving clocks per bit (100 MHz / 9600 baud); legal range 2..65535.
REQ-002 The block SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port TX_DATA  input  8  byte to transmit, sampled when TX_EN=1.
REQ-005 The block SHALL have port TX_EN  input  1  one-cycle send strobe from the peripheral register write.
REQ-006 The block SHALL have port TX_STATUS  output  1  1 = buffer can accept a byte (not full).
REQ-007 The block SHALL have port tx  output  1  serial line, idle high.
REQ-008 The block SHALL have port busy  output  1  1 = frame in progress or buffer non-empty.

Function
REQ-009 The block SHALL buffer bytes in a 4-entry FIFO: 2-bit read pointer, 2-bit write pointer, 3-bit count 0..4, with wrap-around 3->0.
REQ-010 The block SHALL accept a write at a rising edge when TX_EN=1 and the count before that edge's pop is <4; it SHALL silently drop the write otherwise, with no pointer change.
REQ-011 TX_STATUS SHALL equal (count != 4), registered-consistent with count after each edge.
REQ-012 A simultaneous push and pop at count 1..3 SHALL leave count unchanged, advance both pointers, and preserve FIFO order.
REQ-013 The transmitter SHALL run the FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE: tx=1, baud counter held at 0; when count>0, the FSM SHALL pop the head byte into the 8-bit shift register and move to START at that edge.
REQ-015 START: tx=0 for exactly BAUD_DIV clocks, then the FSM SHALL go to DATA with bit index 0.
REQ-016 DATA: tx SHALL equal shift[0], each bit held BAUD_DIV clocks, LSB first, shifting right after each bit; after bit index 7 the FSM SHALL go to STOP.
REQ-017 STOP: tx=1 for exactly BAUD_DIV clocks; at the end, if count>0 the FSM SHALL pop and go directly to START (no idle gap), else it SHALL go to IDLE.
REQ-018 The baud counter SHALL count 0..BAUD_DIV-1, wrap to 0 on each bit boundary, and be 16 bits wide.
REQ-019 The frame length SHALL be exactly 10*BAUD_DIV clocks from the first clock of tx low to the end of the stop bit.
REQ-020 Latency: a byte written at edge E0 with the FIFO empty and the FSM in IDLE SHALL be popped at edge E1, with tx low from E1 onward.
REQ-021 tx SHALL be driven from a register (glitch-free); busy SHALL be (state!=IDLE) || (count!=0).
REQ-022 TX_DATA SHALL be captured only on accepted writes; later changes to TX_DATA SHALL not affect queued or in-flight bytes.

Reset
REQ-023 On reset assertion the block SHALL immediately force: tx=1, state=IDLE, count=0, pointers=0, baud counter=0, bit index=0, shift=0, TX_STATUS=1, busy=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame and discard all buffered bytes; no partial byte SHALL be resumed after release.
REQ-025 The first rising edge after reset release SHALL operate normally, and a TX_EN on that edge SHALL be accepted.

Verification (BAUD_DIV=4)
REQ-026 Single byte: TX_EN with 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks, 40 clocks total, then busy=0.
REQ-027 Back-to-back: 0x00 then 0xFF on consecutive cycles -> two frames with no idle clock between the stop bit and the next start bit.
REQ-028 Overflow: 6 strobes (0x01..0x06) in 6 consecutive cycles from IDLE -> the first pops immediately, so 0x01..0x05 are transmitted and 0x06 is dropped; TX_STATUS=0 from the cycle after the 5th write until the first pop.
REQ-029 Full plus simultaneous pop: count=4 and a strobe on the STOP-end pop edge -> the write is dropped and count=3 afterwards.
REQ-030 Reset mid-DATA (bit 3 of 0x3C) -> tx=1 without waiting for a clock edge, and TX_STATUS=1, busy=0; no further frame appears after release.
REQ-031 Random: 1000 random bytes, strobes issued only when TX_STATUS=1 -> a serial monitor decodes an identical, in-order byte stream.
